sar_result_fifo: RTL and testbench

//  Downstream consumer of the SAR conversion logic.
//  - Captures each finished 8-bit code on the rising edge of eoc.
//  - Optionally averages 2^AVG_LOG2 consecutive codes (oversampling).
//  - Buffers results in a first-word-fall-through FIFO with a valid/ready output stream,
//    so the readout host can drain codes at its own pace.

---
 rtl/sar_result_fifo.sv | 177 +++++++++++++++++
 tb/tb_sar_result_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_result_fifo.sv
// -----------------------------------------------------------------------------
// sar_result_fifo
//
// Downstream consumer of the SAR conversion logic. Each rising edge of eoc
// captures one DW-bit conversion code. Codes are optionally averaged in groups
// of 2**AVG_LOG2 (floor of the mean), and the resulting words are buffered in
// a first-word-fall-through FIFO drained through a valid/ready stream.
//
// Parameters
//   DW        code width
//   DEPTH     FIFO entries (power of 2, >= 2)
//   AVG_LOG2  log2 of samples averaged per output word (0 = pass-through)
//
// Ports
//   clk          in   system clock (shared with the SAR logic)
//   rst          in   synchronous, active-high reset
//   eoc          in   end-of-conversion; a rising edge captures sar
//   sar          in   conversion code
//   flush        in   synchronous clear of FIFO, accumulator and sample count
//   out_ready    in   downstream accepts out_data this cycle
//   clr_ovf      in   clear the sticky overflow flag
//   out_data     out  head-of-FIFO word, meaningful while out_valid
//   out_valid    out  FIFO holds at least one word
//   fifo_count   out  words held, 0..DEPTH
//   almost_full  out  fifo_count >= DEPTH-1
//   overflow     out  sticky: a finished word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module sar_result_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     eoc,
    input  logic [DW-1:0]            sar,
    input  logic                     flush,
    input  logic                     out_ready,
    input  logic                     clr_ovf,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ACC_W  = DW + AVG_LOG2;
    localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    // Value of the sample counter when the current sample completes a group.
    // With AVG_LOG2 = 0 this is 0, so every capture completes a group.
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

    logic                eoc_q;
    logic                cap;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [SCNT_W-1:0]   scnt;
    logic                push;
    logic [DW-1:0]       push_word;
    logic                pop;
    logic                full;
    logic                wr_en;
    logic                drop;

    logic [DW-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // -------------------------------------------------------------------------
    // Datapath control
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here is assigned on every path through the
    // block, so no latch can be inferred.
    always_comb begin
        cap       = eoc & ~eoc_q;
        acc_sum   = acc + ACC_W'(sar);
        // A capture during flush is discarded, so it can never produce a push.
        push      = cap & (scnt == SCNT_LAST) & ~flush;
        // Floor of the mean: the sum of 2**AVG_LOG2 codes always fits ACC_W.
        push_word = DW'(acc_sum >> AVG_LOG2);
        full      = (fifo_count == CNT_FULL);
        pop       = out_valid & out_ready;
        // A full FIFO still accepts a word when the head leaves the same cycle.
        wr_en     = push & (~full | pop);
        drop      = push & full & ~pop;
    end

    // -------------------------------------------------------------------------
    // Edge detector on eoc; flush deliberately leaves it alone so an eoc held
    // high across a flush is not recaptured afterwards.
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            eoc_q <= 1'b0;
        end else begin
            eoc_q <= eoc;
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator, sample counter, pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc        <= '0;
            scnt       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (cap) begin
                if (scnt == SCNT_LAST) begin
                    acc  <= '0;
                    scnt <= '0;
                end else begin
                    acc  <= acc_sum;
                    scnt <= scnt + 1'b1;
                end
            end

            // DEPTH is a power of two, so the pointers wrap naturally.
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set.
    // Flush does not touch it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever read after it
    // has been written, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: first-word-fall-through head, no same-cycle bypass.
    // -------------------------------------------------------------------------
    assign out_data    = mem[rd_ptr];
    assign out_valid   = (fifo_count != '0);
    assign almost_full = (fifo_count >= CNT_ALMOST);

endmodule

// File: tb/tb_sar_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_sar_result_fifo
//
// Two instances share one stimulus stream: index 0 is pass-through
// (AVG_LOG2 = 0), index 1 averages groups of four (AVG_LOG2 = 2). A queue
// model per instance predicts every output each cycle; directed sequences
// with literal expectations pin the model, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_sar_result_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          eoc;
    logic [DW-1:0] sar;
    logic          flush;
    logic          out_ready;
    logic          clr_ovf;

    logic [DW-1:0] od   [2];
    logic          ov   [2];
    logic [3:0]    cnt  [2];
    logic          af   [2];
    logic          ovf  [2];

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state, one set per instance.
    int  mq    [2][$];
    bit  eprev [2];
    int  msum  [2];
    int  mn    [2];
    bit  movf  [2];
    bit  started = 1'b0;

    always #5 clk = ~clk;

    sar_result_fifo #(.DW(DW), .DEPTH(DEPTH), .AVG_LOG2(0)) u_dut_pt (
        .clk        (clk),
        .rst        (rst),
        .eoc        (eoc),
        .sar        (sar),
        .flush      (flush),
        .out_ready  (out_ready),
        .clr_ovf    (clr_ovf),
        .out_data   (od[0]),
        .out_valid  (ov[0]),
        .fifo_count (cnt[0]),
        .almost_full(af[0]),
        .overflow   (ovf[0])
    );

    sar_result_fifo #(.DW(DW), .DEPTH(DEPTH), .AVG_LOG2(2)) u_dut_avg (
        .clk        (clk),
        .rst        (rst),
        .eoc        (eoc),
        .sar        (sar),
        .flush      (flush),
        .out_ready  (out_ready),
        .clr_ovf    (clr_ovf),
        .out_data   (od[1]),
        .out_valid  (ov[1]),
        .fifo_count (cnt[1]),
        .almost_full(af[1]),
        .overflow   (ovf[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the specification's rules, applied with the inputs as
    // they stand at the rising edge.
    task automatic model_step(input int k);
        int  lg;
        bit  cap;
        bit  pop;
        bit  push;
        int  word;
        lg   = (k == 0) ? 0 : 2;
        push = 1'b0;
        word = 0;
        if (rst) begin
            mq[k].delete();
            eprev[k] = 1'b0;
            msum[k]  = 0;
            mn[k]    = 0;
            movf[k]  = 1'b0;
            return;
        end
        cap      = eoc && !eprev[k];
        eprev[k] = eoc;
        pop      = (mq[k].size() > 0) && out_ready;
        if (clr_ovf) movf[k] = 1'b0;
        if (flush) begin
            mq[k].delete();
            msum[k] = 0;
            mn[k]   = 0;
            return;
        end
        if (cap) begin
            msum[k] += int'(sar);
            mn[k]++;
            if (mn[k] == (1 << lg)) begin
                word    = msum[k] >> lg;
                push    = 1'b1;
                msum[k] = 0;
                mn[k]   = 0;
            end
        end
        if (pop) void'(mq[k].pop_front());
        if (push) begin
            if (mq[k].size() < DEPTH) mq[k].push_back(word);
            else                      movf[k] = 1'b1;
        end
    endtask

    task automatic compare(input int k);
        int sz;
        sz = mq[k].size();
        check($sformatf("dut%0d out_valid", k), 32'(ov[k]), 32'(sz != 0));
        check($sformatf("dut%0d fifo_count", k), 32'(cnt[k]), 32'(sz));
        check($sformatf("dut%0d almost_full", k), 32'(af[k]), 32'(sz >= DEPTH - 1));
        check($sformatf("dut%0d overflow", k), 32'(ovf[k]), 32'(movf[k]));
        if (sz != 0) check($sformatf("dut%0d out_data", k), 32'(od[k]), 32'(mq[k][0]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [DW-1:0] code);
        eoc = 1'b1;
        sar = code;
        tick();
        eoc = 1'b0;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; eoc = 1'b0; sar = '0; flush = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;

        fork
            forever begin
                @(posedge clk);
                model_step(0);
                model_step(1);
                if (rst) started = 1'b1;
            end
            forever begin
                @(negedge clk);
                if (started) begin
                    compare(0);
                    compare(1);
                end
            end
        join_none

        // Reset state
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst dut%0d out_valid", k), 32'(ov[k]), 32'd0);
            check($sformatf("rst dut%0d fifo_count", k), 32'(cnt[k]), 32'd0);
            check($sformatf("rst dut%0d almost_full", k), 32'(af[k]), 32'd0);
            check($sformatf("rst dut%0d overflow", k), 32'(ovf[k]), 32'd0);
        end

        // 1: pass-through, one-cycle latency, ordered drain
        eoc = 1'b1; sar = 8'h12;
        tick();
        check("t1 latency out_valid", 32'(ov[0]), 32'd1);
        check("t1 latency out_data", 32'(od[0]), 32'h12);
        eoc = 1'b0;
        tick();
        pulse(8'h34);
        pulse(8'h56);
        check("t1 fifo_count", 32'(cnt[0]), 32'd3);
        check("t1 head", 32'(od[0]), 32'h12);
        check("t1 avg no word yet", 32'(cnt[1]), 32'd0);
        out_ready = 1'b1;
        check("t1 drain 0", 32'(od[0]), 32'h12);
        tick();
        check("t1 drain 1", 32'(od[0]), 32'h34);
        tick();
        check("t1 drain 2", 32'(od[0]), 32'h56);
        tick();
        check("t1 empty", 32'(ov[0]), 32'd0);
        out_ready = 1'b0;
        do_flush();

        // 2: average of 10,11,12,13 = 46 >> 2 = 11
        pulse(8'd10); pulse(8'd11); pulse(8'd12);
        check("t2 no word after 3", 32'(ov[1]), 32'd0);
        eoc = 1'b1; sar = 8'd13;
        tick();
        check("t2 valid", 32'(ov[1]), 32'd1);
        check("t2 word", 32'(od[1]), 32'd11);
        eoc = 1'b0;
        tick();
        do_flush();

        // 3: overflow on the ninth word, first eight survive
        for (int i = 0; i < 9; i++) pulse(8'(8'h60 + i));
        check("t3 count", 32'(cnt[0]), 32'd8);
        check("t3 almost_full", 32'(af[0]), 32'd1);
        check("t3 overflow", 32'(ovf[0]), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3 drain %0d", i), 32'(od[0]), 32'(8'h60 + i));
            tick();
        end
        check("t3 empty", 32'(ov[0]), 32'd0);
        out_ready = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3 clr_ovf", 32'(ovf[0]), 32'd0);
        do_flush();

        // 4: push and pop on a full FIFO
        for (int i = 0; i < 8; i++) pulse(8'(8'h70 + i));
        check("t4 full", 32'(cnt[0]), 32'd8);
        eoc = 1'b1; sar = 8'h99; out_ready = 1'b1;
        tick();
        check("t4 count stays", 32'(cnt[0]), 32'd8);
        check("t4 no overflow", 32'(ovf[0]), 32'd0);
        check("t4 new head", 32'(od[0]), 32'h71);
        eoc = 1'b0; out_ready = 1'b0;
        tick();
        pulse(8'hAA);
        check("t4 drop sets overflow", 32'(ovf[0]), 32'd1);
        do_flush();
        check("t4 flush keeps overflow", 32'(ovf[0]), 32'd1);
        check("t4 flush empties", 32'(cnt[0]), 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // 5: eoc held high three cycles is one capture
        eoc = 1'b1; sar = 8'hA5;
        tick(); tick(); tick();
        eoc = 1'b0;
        tick();
        check("t5 one word", 32'(cnt[0]), 32'd1);
        check("t5 word", 32'(od[0]), 32'hA5);
        do_flush();

        // Capture coincident with flush is discarded
        eoc = 1'b1; sar = 8'h33; flush = 1'b1;
        tick();
        flush = 1'b0; eoc = 1'b0;
        tick();
        check("flush+cap discarded", 32'(cnt[0]), 32'd0);

        // 6: flush drops a partial average
        pulse(8'h05); pulse(8'h07);
        do_flush();
        for (int i = 0; i < 4; i++) pulse(8'h40);
        check("t6 one word", 32'(cnt[1]), 32'd1);
        check("t6 word", 32'(od[1]), 32'h40);
        check("t6 overflow unchanged", 32'(ovf[1]), 32'd0);
        do_flush();

        // Reset mid-operation
        pulse(8'h01); pulse(8'h02); pulse(8'h03);
        check("mid-rst pre count", 32'(cnt[0]), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-rst out_valid", 32'(ov[0]), 32'd0);
        check("mid-rst count", 32'(cnt[0]), 32'd0);
        tick();
        check("mid-rst stays empty", 32'(ov[0]), 32'd0);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            eoc       = ($urandom_range(0, 9) < 4);
            sar       = 8'($urandom);
            out_ready = ((c % 800) < 300) ? ($urandom_range(0, 9) == 0)
                                          : 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) == 0);
            clr_ovf   = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; eoc = 1'b0; flush = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
